// File: rtl/cache_fill_pkg.sv
// Shared types and width helpers for the cache line fill controller.
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } fill_state_t;

    function automatic int idx_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int off_width(input int words_per_line, input int word_bytes);
        return $clog2(words_per_line * word_bytes);
    endfunction

    function automatic int wb_width(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear and enable; used for fill request/return tracking.
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: registers are written with <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: issues per-word memory reads, writes returns into the line, then the tag.
// Define CACHE_FILL_CWF_EN to fetch the missed word first and wrap around the line.
module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int WORD_BYTES     = 2,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 miss_detected,
    input  logic [ADDR_W-1:0]                    miss_address,
    output logic                                 fsm_busy,
    output logic                                 mem_rd_en,
    input  logic                                 mem_ready,
    output logic [ADDR_W-1:0]                    memory_address,
    input  logic                                 memory_data_valid,
    output logic                                 cache_wr_en,
    output logic [idx_width(WORDS_PER_LINE)-1:0] cache_wr_word,
    output logic                                 tag_wr_en,
    output logic [ADDR_W-1:0]                    fill_line_addr,
    output logic                                 fill_done
);

    localparam int IDX_W = idx_width(WORDS_PER_LINE);
    localparam int OFF_W = off_width(WORDS_PER_LINE, WORD_BYTES);
    localparam int WB_W  = wb_width(WORD_BYTES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

    fill_state_t       r_state;
    fill_state_t       w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_start;
    logic [IDX_W-1:0]  w_start;
    logic [CNT_W-1:0]  w_issue_cnt;
    logic [CNT_W-1:0]  w_rcv_cnt;
    logic [CNT_W-1:0]  w_issue_off;
    logic [IDX_W-1:0]  w_issue_idx;
    logic              w_capture;
    logic              w_accept;
    logic              w_rcv;
    logic              w_active;
    logic              w_last_rcv;

`ifdef CACHE_FILL_CWF_EN
    assign w_start = miss_address[OFF_W-1:WB_W];
`else
    assign w_start = '0;
`endif

    assign w_active   = (r_state == ISSUE) || (r_state == WAIT);
    assign w_capture  = (r_state == IDLE) && miss_detected;
    assign w_accept   = (r_state == ISSUE) && mem_ready;
    assign w_rcv      = w_active && memory_data_valid && (w_rcv_cnt < w_issue_cnt);
    assign w_last_rcv = w_rcv && (w_rcv_cnt == LAST);

    fill_counter #(.W(CNT_W)) issue_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_capture),
        .i_en    (w_accept),
        .o_count (w_issue_cnt)
    );

    fill_counter #(.W(CNT_W)) rcv_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_capture),
        .i_en    (w_rcv),
        .o_count (w_rcv_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_start <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_base  <= miss_address & LINE_MASK;
                r_start <= w_start;
            end
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (miss_detected) w_next_state = ISSUE;
            ISSUE:   if (w_accept && (w_issue_cnt == LAST)) w_next_state = w_last_rcv ? DONE : WAIT;
            WAIT:    if (w_last_rcv) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outside ISSUE the address points at the last word requested, so it holds through WAIT.
    assign w_issue_off    = ((r_state == ISSUE) || (w_issue_cnt == '0)) ? w_issue_cnt
                                                                        : w_issue_cnt - CNT_W'(1);
    assign w_issue_idx    = IDX_W'({1'b0, r_start} + w_issue_off);
    assign memory_address = r_base | (ADDR_W'(w_issue_idx) << WB_W);
    assign mem_rd_en      = (r_state == ISSUE);
    assign cache_wr_en    = w_rcv;
    assign cache_wr_word  = IDX_W'({1'b0, r_start} + w_rcv_cnt);
    assign fsm_busy       = (r_state != IDLE);
    assign tag_wr_en      = (r_state == DONE);
    assign fill_done      = (r_state == DONE);
    assign fill_line_addr = r_base;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: default 8x2-byte line plus a 4x4-byte, 32-bit instance.
module tb_cache_fill_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_rd_en;
    logic        mem_ready;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic        cache_wr_en;
    logic [2:0]  cache_wr_word;
    logic        tag_wr_en;
    logic [15:0] fill_line_addr;
    logic        fill_done;

    logic        sm_miss;
    logic [31:0] sm_miss_addr;
    logic        sm_busy;
    logic        sm_rd_en;
    logic        sm_ready;
    logic [31:0] sm_mem_addr;
    logic        sm_valid;
    logic        sm_wr_en;
    logic [1:0]  sm_wr_word;
    logic        sm_tag;
    logic [31:0] sm_line;
    logic        sm_done;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_rd_en         (mem_rd_en),
        .mem_ready         (mem_ready),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .cache_wr_en       (cache_wr_en),
        .cache_wr_word     (cache_wr_word),
        .tag_wr_en         (tag_wr_en),
        .fill_line_addr    (fill_line_addr),
        .fill_done         (fill_done)
    );

    cache_fill_ctrl #(.ADDR_W(32), .WORD_BYTES(4), .WORDS_PER_LINE(4)) dut_small (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (sm_miss),
        .miss_address      (sm_miss_addr),
        .fsm_busy          (sm_busy),
        .mem_rd_en         (sm_rd_en),
        .mem_ready         (sm_ready),
        .memory_address    (sm_mem_addr),
        .memory_data_valid (sm_valid),
        .cache_wr_en       (sm_wr_en),
        .cache_wr_word     (sm_wr_word),
        .tag_wr_en         (sm_tag),
        .fill_line_addr    (sm_line),
        .fill_done         (sm_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stall_a, stall_b, stray_a, stray_b;
    logic [L-1:0] pipe;

    logic [15:0] exp_addr [8];
    logic [2:0]  exp_word [8];

    logic [15:0] acc_addr_q [$];
    int          acc_cyc_q  [$];
    logic [2:0]  wr_word_q  [$];
    int          wr_cyc_q   [$];
    int          tag_cyc_q  [$];
    logic [15:0] tag_addr_q [$];
    logic        busy_hist  [int];
    logic [15:0] addr_hist  [int];

    logic        s_busy, s_rd_en, s_wr_en, s_tag, s_done;
    logic [15:0] s_addr, s_line;
    logic [2:0]  s_wr_word;

    task automatic clear_logs();
        acc_addr_q.delete(); acc_cyc_q.delete();
        wr_word_q.delete();  wr_cyc_q.delete();
        tag_cyc_q.delete();  tag_addr_q.delete();
        busy_hist.delete();  addr_hist.delete();
        stall_a = -100; stall_b = -100; stray_a = -100; stray_b = -100;
    endtask

    // One clock: sample at negedge, then advance memory model and inputs after posedge.
    task automatic do_cycle();
        logic acc;
        @(negedge clk);
        acc = ((mem_rd_en & mem_ready) === 1'b1);
        s_busy = fsm_busy; s_rd_en = mem_rd_en; s_wr_en = cache_wr_en; s_tag = tag_wr_en;
        s_done = fill_done; s_addr = memory_address; s_line = fill_line_addr; s_wr_word = cache_wr_word;
        busy_hist[cyc] = fsm_busy;
        addr_hist[cyc] = memory_address;
        if (acc) begin acc_addr_q.push_back(memory_address); acc_cyc_q.push_back(cyc); end
        if (cache_wr_en === 1'b1) begin wr_word_q.push_back(cache_wr_word); wr_cyc_q.push_back(cyc); end
        if (tag_wr_en === 1'b1) begin tag_cyc_q.push_back(cyc); tag_addr_q.push_back(fill_line_addr); end
        checks++;
        if (fill_done !== tag_wr_en) begin
            errors++;
            $display("FAIL done_with_tag cyc=%0d fill_done=%b expected=%b", cyc, fill_done, tag_wr_en);
        end
        @(posedge clk); #1;
        cyc++;
        pipe = {pipe[L-2:0], acc};
        memory_data_valid = pipe[L-1] | (cyc == stray_a) | (cyc == stray_b);
        mem_ready = !((cyc == stall_a) || (cyc == stall_b));
    endtask

    task automatic start_miss(input logic [15:0] addr, output int t0);
        t0 = cyc;
        miss_detected = 1'b1;
        miss_address  = addr;
        do_cycle();
        miss_detected = 1'b0;
        miss_address  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        do_cycle();
        do_cycle();
        checks++;
        if ({s_busy, s_rd_en, s_wr_en, s_tag, s_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy/rd/wr/tag/done=%b expected 00000",
                     {s_busy, s_rd_en, s_wr_en, s_tag, s_done});
        end
        checks++;
        if ({s_addr, s_line, s_wr_word} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h line=%h word=%0d expected all 0", s_addr, s_line, s_wr_word);
        end
        checks++;
        if ({sm_busy, sm_rd_en, sm_wr_en, sm_tag, sm_done, sm_mem_addr, sm_line} !== '0) begin
            errors++;
            $display("FAIL reset_small busy=%b rd=%b addr=%h line=%h expected all 0",
                     sm_busy, sm_rd_en, sm_mem_addr, sm_line);
        end
        rst_n = 1'b1;
        do_cycle();
    endtask

    task automatic test_basic();
        int t0;
        clear_logs();
        start_miss(16'h1A36, t0);
        repeat (20) do_cycle();
        checks++;
        if (acc_addr_q.size() != 8) begin
            errors++; $display("FAIL basic_req_count got %0d expected 8", acc_addr_q.size());
        end
        for (int i = 0; i < 8 && i < acc_addr_q.size(); i++) begin
            checks++;
            if (acc_addr_q[i] !== exp_addr[i] || acc_cyc_q[i] != t0 + 1 + i) begin
                errors++;
                $display("FAIL basic_req[%0d] addr=%h at T+%0d expected %h at T+%0d",
                         i, acc_addr_q[i], acc_cyc_q[i] - t0, exp_addr[i], 1 + i);
            end
        end
        checks++;
        if (wr_word_q.size() != 8) begin
            errors++; $display("FAIL basic_wr_count got %0d expected 8", wr_word_q.size());
        end
        for (int i = 0; i < 8 && i < wr_word_q.size(); i++) begin
            checks++;
            if (wr_word_q[i] !== exp_word[i] || wr_cyc_q[i] != t0 + 5 + i) begin
                errors++;
                $display("FAIL basic_wr[%0d] word=%0d at T+%0d expected %0d at T+%0d",
                         i, wr_word_q[i], wr_cyc_q[i] - t0, exp_word[i], 5 + i);
            end
        end
        checks++;
        if (tag_cyc_q.size() != 1 || tag_cyc_q[0] != t0 + 13 || tag_addr_q[0] !== 16'h1A30) begin
            errors++;
            $display("FAIL basic_tag count=%0d expected one tag at T+13 with line 1a30", tag_cyc_q.size());
        end
        checks++;
        if ({busy_hist[t0], busy_hist[t0+1], busy_hist[t0+13], busy_hist[t0+14]} !== 4'b0110) begin
            errors++;
            $display("FAIL basic_busy T/T+1/T+13/T+14=%b%b%b%b expected 0110",
                     busy_hist[t0], busy_hist[t0+1], busy_hist[t0+13], busy_hist[t0+14]);
        end
    endtask

    task automatic test_stall();
        int t0;
        int exp_off [8] = '{1, 4, 5, 6, 7, 8, 9, 10};
        clear_logs();
        stall_a = cyc + 2;
        stall_b = cyc + 3;
        start_miss(16'h1A36, t0);
        repeat (20) do_cycle();
        checks++;
        if (addr_hist[t0+2] !== exp_addr[1] || addr_hist[t0+3] !== exp_addr[1]) begin
            errors++;
            $display("FAIL stall_hold addr T+2=%h T+3=%h expected %h",
                     addr_hist[t0+2], addr_hist[t0+3], exp_addr[1]);
        end
        checks++;
        if (acc_addr_q.size() != 8) begin
            errors++; $display("FAIL stall_req_count got %0d expected 8", acc_addr_q.size());
        end
        for (int i = 0; i < 8 && i < acc_addr_q.size(); i++) begin
            checks++;
            if (acc_addr_q[i] !== exp_addr[i] || acc_cyc_q[i] != t0 + exp_off[i]) begin
                errors++;
                $display("FAIL stall_req[%0d] addr=%h at T+%0d expected %h at T+%0d",
                         i, acc_addr_q[i], acc_cyc_q[i] - t0, exp_addr[i], exp_off[i]);
            end
        end
        checks++;
        if (tag_cyc_q.size() != 1 || tag_cyc_q[0] != t0 + 15) begin
            errors++; $display("FAIL stall_done tags=%0d expected one at T+15", tag_cyc_q.size());
        end
    endtask

    task automatic test_ignore();
        int t0;
        clear_logs();
        stray_a = cyc + 1;
        do_cycle();
        do_cycle();
        stray_b = cyc + 1;
        start_miss(16'h1A36, t0);
        for (int i = 1; i <= 20; i++) begin
            miss_detected = (i == 3 || i == 4);
            miss_address  = (i == 3 || i == 4) ? 16'h2000 : 16'h0000;
            do_cycle();
        end
        checks++;
        if (wr_word_q.size() != 8 || wr_cyc_q[0] != t0 + 5) begin
            errors++;
            $display("FAIL ignore_stray_valid writes=%0d first at T+%0d expected 8 from T+5",
                     wr_word_q.size(), wr_cyc_q.size() > 0 ? wr_cyc_q[0] - t0 : -1);
        end
        checks++;
        if (acc_addr_q.size() != 8 || acc_addr_q[7] !== exp_addr[7]) begin
            errors++; $display("FAIL ignore_requests count=%0d expected 8 ending %h", acc_addr_q.size(), exp_addr[7]);
        end
        checks++;
        if (tag_addr_q.size() != 1 || tag_addr_q[0] !== 16'h1A30) begin
            errors++; $display("FAIL ignore_recapture tags=%0d expected one with line 1a30", tag_addr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_logs();
        start_miss(16'h1A36, t0);
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        repeat (14) do_cycle();
        miss_detected = 1'b0;
        miss_address  = '0;
        repeat (16) do_cycle();
        checks++;
        if (tag_cyc_q.size() != 2) begin
            errors++; $display("FAIL b2b_tag_count got %0d expected 2", tag_cyc_q.size());
        end else begin
            checks++;
            if (tag_cyc_q[0] != t0 + 13 || tag_cyc_q[1] != t0 + 27) begin
                errors++;
                $display("FAIL b2b_tag_time T+%0d,T+%0d expected T+13,T+27", tag_cyc_q[0] - t0, tag_cyc_q[1] - t0);
            end
            checks++;
            if (tag_addr_q[0] !== 16'h1A30 || tag_addr_q[1] !== 16'h2000) begin
                errors++;
                $display("FAIL b2b_line got %h,%h expected 1a30,2000", tag_addr_q[0], tag_addr_q[1]);
            end
        end
        checks++;
        if (busy_hist[t0+14] !== 1'b0 || busy_hist[t0+15] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap busy T+14=%b T+15=%b expected 0,1", busy_hist[t0+14], busy_hist[t0+15]);
        end
        checks++;
        if (acc_addr_q.size() != 16 || acc_addr_q[8] !== 16'h2000 || acc_addr_q[15] !== 16'h200E
            || acc_cyc_q[8] != t0 + 15) begin
            errors++;
            $display("FAIL b2b_second_fill reqs=%0d expected 16 with 2000..200e from T+15", acc_addr_q.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        int t0;
        int t1;
        clear_logs();
        start_miss(16'h1A36, t0);
        repeat (5) do_cycle();
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        do_cycle();
        checks++;
        if ({s_busy, s_rd_en, s_wr_en, s_tag, s_done} !== 5'b0 || {s_addr, s_line, s_wr_word} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs busy=%b rd=%b wr=%b tag=%b addr=%h line=%h expected all 0",
                     s_busy, s_rd_en, s_wr_en, s_tag, s_addr, s_line);
        end
        repeat (10) do_cycle();
        checks++;
        if (tag_cyc_q.size() != 0 || wr_word_q.size() != 2) begin
            errors++;
            $display("FAIL midreset_abandon tags=%0d writes=%0d expected 0 tags, 2 writes",
                     tag_cyc_q.size(), wr_word_q.size());
        end
        clear_logs();
        start_miss(16'h1A36, t1);
        repeat (20) do_cycle();
        checks++;
        if (wr_word_q.size() != 8 || tag_cyc_q.size() != 1 || acc_addr_q.size() != 8) begin
            errors++;
            $display("FAIL midreset_refill writes=%0d tags=%0d reqs=%0d expected 8,1,8",
                     wr_word_q.size(), tag_cyc_q.size(), acc_addr_q.size());
        end else begin
            checks++;
            if (tag_cyc_q[0] != t1 + 13 || tag_addr_q[0] !== 16'h1A30 || acc_addr_q[0] !== exp_addr[0]
                || wr_word_q[0] !== exp_word[0]) begin
                errors++;
                $display("FAIL midreset_refill_order tag T+%0d line=%h first=%h expected T+13 1a30 %h",
                         tag_cyc_q[0] - t1, tag_addr_q[0], acc_addr_q[0], exp_addr[0]);
            end
        end
    endtask

    task automatic test_small_line();
        logic [31:0] aq [$];
        logic [1:0]  wq [$];
        logic [31:0] sm_exp_addr [4];
        logic [1:0]  sm_exp_word [4];
        int          tags;
        int          tag_c;
        logic [31:0] tag_line;
        logic        acc;
`ifdef CACHE_FILL_CWF_EN
        sm_exp_addr = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
        sm_exp_word = '{2'd1, 2'd2, 2'd3, 2'd0};
`else
        sm_exp_addr = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        sm_exp_word = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
        tags = 0; tag_c = -1; tag_line = '0;
        sm_miss = 1'b1;
        sm_miss_addr = 32'h0000_1234;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            acc = ((sm_rd_en & sm_ready) === 1'b1);
            if (acc) aq.push_back(sm_mem_addr);
            if (sm_wr_en === 1'b1) wq.push_back(sm_wr_word);
            if (sm_tag === 1'b1) begin tags++; tag_c = c; tag_line = sm_line; end
            @(posedge clk); #1;
            sm_miss  = 1'b0;
            sm_valid = acc;
        end
        checks++;
        if (aq.size() != 4 || wq.size() != 4) begin
            errors++; $display("FAIL small_counts reqs=%0d writes=%0d expected 4,4", aq.size(), wq.size());
        end
        for (int i = 0; i < 4 && i < aq.size() && i < wq.size(); i++) begin
            checks++;
            if (aq[i] !== sm_exp_addr[i] || wq[i] !== sm_exp_word[i]) begin
                errors++;
                $display("FAIL small_word[%0d] addr=%h word=%0d expected %h,%0d",
                         i, aq[i], wq[i], sm_exp_addr[i], sm_exp_word[i]);
            end
        end
        checks++;
        if (tags != 1 || tag_c != 6 || tag_line !== 32'h0000_1230) begin
            errors++;
            $display("FAIL small_tag count=%0d at %0d line=%h expected 1 at 6 line 00001230", tags, tag_c, tag_line);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        miss_detected = 1'b0;
        miss_address = '0;
        mem_ready = 1'b1;
        memory_data_valid = 1'b0;
        sm_miss = 1'b0;
        sm_miss_addr = '0;
        sm_ready = 1'b1;
        sm_valid = 1'b0;
        pipe = '0;
        clear_logs();
`ifdef CACHE_FILL_CWF_EN
        exp_addr = '{16'h1A36, 16'h1A38, 16'h1A3A, 16'h1A3C, 16'h1A3E, 16'h1A30, 16'h1A32, 16'h1A34};
        exp_word = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
`else
        exp_addr = '{16'h1A30, 16'h1A32, 16'h1A34, 16'h1A36, 16'h1A38, 16'h1A3A, 16'h1A3C, 16'h1A3E};
        exp_word = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        test_reset();
        test_basic();
        test_stall();
        test_ignore();
        test_back_to_back();
        test_reset_mid_fill();
        test_small_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
